// File: rtl/seq_restoring_divider_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package seq_restoring_divider_pkg;

  localparam int DIV_WIDTH_DEF = 4;

  // Iteration counter must be able to hold WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_width(DIV_WIDTH_DEF);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Request/response bundle for the divider: operands in, status and results out.
interface seq_restoring_divider_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider_sub.sv
// Combinational a - b with borrow-lookahead: generate/propagate terms mirror
// the carry logic of the lookahead adder.
module borrow_lookahead_sub #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);
  logic [W-1:0] g, p;
  logic [W:0]   bw;

  // A bit generates a borrow when a=0,b=1 and passes one through when a==b.
  assign g = ~a & b;
  assign p = ~(a ^ b);

  always_comb begin
    bw = '0;
    for (int i = 0; i < W; i++) begin
      logic acc;
      acc = 1'b0;
      for (int j = 0; j <= i; j++) acc = g[j] | (p[j] & acc);
      bw[i+1] = acc;
    end
  end

  assign diff   = a ^ b ^ bw[W-1:0];
  assign borrow = bw[W];
endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// divide-by-zero short-circuits straight to DONE.
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input logic                   clk,
  input logic                   rst_n,
  seq_restoring_divider_if.slave bus
);
  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] d_q, v_q, q_sh;
  logic [WIDTH:0]   r_q, r_sh, diff, r_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             borrow, accept, last_step, zero_div;
  logic [WIDTH-1:0] quot_q, rem_q;
  logic             dbz_q;
  logic             unused_r_msb;

  assign accept    = bus.start && (state_q != S_RUN);
  assign zero_div  = (bus.divisor == '0);
  assign last_step = (state_q == S_RUN) && (cnt_q == CW'(WIDTH - 1));

  assign r_sh = {r_q[WIDTH-1:0], d_q[WIDTH-1]};

  borrow_lookahead_sub #(.W(WIDTH + 1)) u_sub (
    .a     (r_sh),
    .b     ({1'b0, v_q}),
    .diff  (diff),
    .borrow(borrow)
  );

  assign r_nxt = borrow ? r_sh : diff;
  assign q_nxt = {q_sh[WIDTH-2:0], ~borrow};

  // Stored R is always below V, so its top bit never carries information.
  assign unused_r_msb = r_q[WIDTH];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) state_d = zero_div ? S_DONE : S_RUN;
        else           state_d = S_IDLE;
      end
      S_RUN:   if (last_step) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      d_q   <= '0;
      v_q   <= '0;
      r_q   <= '0;
      q_sh  <= '0;
    end else if (accept) begin
      cnt_q <= '0;
      d_q   <= bus.dividend;
      v_q   <= bus.divisor;
      r_q   <= '0;
    end else if (state_q == S_RUN) begin
      cnt_q <= cnt_q + CW'(1);
      d_q   <= d_q << 1;
      r_q   <= r_nxt;
      q_sh  <= q_nxt;
    end
  end

  // Results hold until the next completion; accept alone does not clear them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quot_q <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else if (accept && zero_div) begin
      quot_q <= '1;
      rem_q  <= bus.dividend;
      dbz_q  <= 1'b1;
    end else if (last_step) begin
      quot_q <= q_nxt;
      rem_q  <= r_nxt[WIDTH-1:0];
      dbz_q  <= 1'b0;
    end
  end

  assign bus.busy        = (state_q == S_RUN);
  assign bus.done        = (state_q == S_DONE);
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
endmodule
